i2s_rx: RTL and testbench

//  I2S receiver (slave) for an external audio source such as a codec ADC or line-in.
//  - Oversamples SCLK/LRCLK/SDATA in the system clock domain (clk_114 in the top level).
//  - Deserialises standard Philips I2S frames into 16-bit left/right samples.
//  - Presents each complete stereo pair with a one-cycle strobe.
//  - It is the receive-side counterpart of i2s_tx; an i2s_tx -> i2s_rx loopback must be lossless.

---
 rtl/i2s_rx_pkg.sv | 8 +
 rtl/i2s_in_sync.sv | 35 +++
 rtl/i2s_rx.sv | 101 ++++++++++
 tb/tb_i2s_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared constants for the I2S receive path: default sample width and FSM encodings.
package i2s_rx_pkg;
   localparam int I2S_WIDTH = 16;

   localparam logic [1:0] I2S_SYNC  = 2'd0;
   localparam logic [1:0] I2S_LEFT  = 2'd1;
   localparam logic [1:0] I2S_RIGHT = 2'd2;
endpackage

// File: rtl/i2s_in_sync.sv
// N-stage synchroniser for a small bus of async pins; bit 0 also gets a registered rise detector.
module i2s_in_sync #(
   parameter int N = 2,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:1] sync,
   output logic         rise
);
   logic [N-1:0] chain [W];
   logic         sync0_d;

   for (genvar b = 0; b < W; b++) begin : g_bit
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) chain[b] <= '0;
         else      chain[b] <= {chain[b][N-2:0], din[b]};
      end
      if (b > 0) begin : g_out
         assign sync[b] = chain[b][N-1];
      end
   end

   // Edge is registered once more so the strobe is a clean single-cycle pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync0_d <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync0_d <= chain[0][N-1];
         rise    <= chain[0][N-1] & ~sync0_d;
      end
   end
endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversampled pins, Philips framing, left/right pair presented with a 1-clk strobe.
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int WIDTH       = I2S_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             lrclk,
   input  logic             sdata,
   output logic [WIDTH-1:0] left_chan,
   output logic [WIDTH-1:0] right_chan,
   output logic             sample_valid,
   output logic             locked
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [2:1]       pins_s;
   logic             sclk_rise;
   logic             lr_s, sd_s;
   logic [WIDTH-1:0] sreg, sreg_nx, word, left_hold;
   logic [CW-1:0]    bitcnt, bitcnt_nx;
   logic [1:0]       state;
   logic             lr_prev, primed, have_left, boundary;

   i2s_in_sync #(.N(SYNC_STAGES), .W(3)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  ({sdata, lrclk, sclk}),
      .sync (pins_s),
      .rise (sclk_rise)
   );

   assign lr_s = pins_s[1];
   assign sd_s = pins_s[2];

   // The boundary bit still belongs to the old slot, so word includes it before justification.
   always_comb begin
      sreg_nx   = sreg;
      bitcnt_nx = bitcnt;
      if (bitcnt < CW'(WIDTH)) begin
         sreg_nx   = {sreg[WIDTH-2:0], sd_s};
         bitcnt_nx = bitcnt + 1'b1;
      end
      word     = sreg_nx << (CW'(WIDTH) - bitcnt_nx);
      boundary = sclk_rise && primed && (lr_s != lr_prev);
   end

   // primed keeps the very first rise after reset from being mistaken for a slot boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg         <= '0;
         bitcnt       <= '0;
         state        <= I2S_SYNC;
         lr_prev      <= 1'b0;
         primed       <= 1'b0;
         have_left    <= 1'b0;
         left_hold    <= '0;
         left_chan    <= '0;
         right_chan   <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (sclk_rise) begin
            lr_prev <= lr_s;
            primed  <= 1'b1;
            if (boundary) begin
               sreg   <= '0;
               bitcnt <= '0;
               case (state)
                  I2S_SYNC: begin
                     state  <= lr_s ? I2S_RIGHT : I2S_LEFT;
                     locked <= 1'b1;
                  end
                  I2S_LEFT: begin
                     left_hold <= word;
                     have_left <= 1'b1;
                     state     <= I2S_RIGHT;
                  end
                  I2S_RIGHT: begin
                     // A right slot entered straight from SYNC has no matching left half.
                     if (have_left) begin
                        left_chan    <= left_hold;
                        right_chan   <= word;
                        sample_valid <= 1'b1;
                     end
                     state <= I2S_LEFT;
                  end
                  default: state <= I2S_SYNC;
               endcase
            end else begin
               sreg   <= sreg_nx;
               bitcnt <= bitcnt_nx;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a bit-level I2S source feeds the DUT, a monitor scores each strobe.
module tb_i2s_rx;
   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
   } pair_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        sclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
   logic [15:0] left_chan, right_chan;
   logic        sample_valid, locked;

   int    tests = 0, fails = 0, pulses = 0, pulses0;
   logic  pending = 1'b0;
   logic  sv_prev = 1'b0;
   pair_t exp_q[$];
   pair_t e;

   i2s_rx dut (
      .clk          (clk),
      .rst          (rst),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .left_chan    (left_chan),
      .right_chan   (right_chan),
      .sample_valid (sample_valid),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   // Scoreboard side: every strobe must match the oldest expected pair.
   always @(negedge clk) begin
      if (rst && sample_valid) begin
         pulses++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got L=%h R=%h, required no strobe", left_chan, right_chan);
         end else begin
            e = exp_q.pop_front();
            if ({left_chan, right_chan} !== e) begin
               fails++;
               $display("FAIL pair: got L=%h R=%h, required L=%h R=%h", left_chan, right_chan, e.l, e.r);
            end
         end
         tests++;
         if (sv_prev !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL strobe_shape: prev_valid=%b locked=%b, required prev_valid=0 locked=1", sv_prev, locked);
         end
      end
      sv_prev = sample_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // One bit period: pins change with sclk low, receiver samples on the rise.
   task automatic send_bit(input logic lr, input logic sd);
      sclk = 1'b0; lrclk = lr; sdata = sd;
      #40;
      sclk = 1'b1;
      #40;
   endtask

   // Philips framing: each bit travels one period late, so a slot's LSB rides the next slot's first edge.
   task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         send_bit(lr, pending);
         pending = data[i];
      end
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      exp_q.push_back({l, r});
   endtask

   task automatic flush();
      send_bit(1'b0, pending);
      pending = 1'b0;
      sclk = 1'b0;
      #100;
   endtask

   task automatic do_reset();
      rst = 1'b0; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; pending = 1'b0;
      #50;
      check("rst_left", 32'(left_chan), 32'h0);
      check("rst_right", 32'(right_chan), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      rst = 1'b1;
      #20;
   endtask

   initial begin
      // Pins toggling while held in reset
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_bit(i[0], ~i[1]);
      check("inrst_left", 32'(left_chan), 32'h0);
      check("inrst_right", 32'(right_chan), 32'h0);
      check("inrst_valid", 32'(sample_valid), 32'h0);
      check("inrst_locked", 32'(locked), 32'h0);
      sclk = 1'b0; lrclk = 1'b1; pending = 1'b0;
      #50;
      rst = 1'b1;
      #20;

      // Lock only after the first lrclk change, then full 16-bit stereo pairs
      send_slot(1'b1, 32'h0, 6);
      check("locked_before_boundary", 32'(locked), 32'h0);
      send_slot(1'b0, 32'hA55A, 16);
      check("locked_after_boundary", 32'(locked), 32'h1);
      send_slot(1'b1, 32'h1234, 16); push(16'hA55A, 16'h1234);
      send_slot(1'b0, 32'hA55A, 16);
      send_slot(1'b1, 32'h1234, 16); push(16'hA55A, 16'h1234);
      flush();

      // 32-bit slots truncate to the first 16 bits
      do_reset();
      send_slot(1'b1, 32'h0, 5);
      send_slot(1'b0, 32'h8001FFFF, 32);
      send_slot(1'b1, 32'h7FFE0000, 32); push(16'h8001, 16'h7FFE);
      flush();

      // 8-bit slots are left-justified; outputs hold while sclk stalls
      do_reset();
      send_slot(1'b1, 32'h0, 5);
      send_slot(1'b0, 32'hC3, 8);
      send_slot(1'b1, 32'h01, 8); push(16'hC300, 16'h0100);
      flush();
      #500;
      check("stall_hold_left", 32'(left_chan), 32'hC300);
      check("stall_hold_right", 32'(right_chan), 32'h0100);

      // 1-bit slots
      do_reset();
      send_slot(1'b1, 32'h0, 3);
      send_slot(1'b0, 32'h1, 1);
      send_slot(1'b1, 32'h1, 1); push(16'h8000, 16'h8000);
      send_slot(1'b0, 32'h1, 1);
      send_slot(1'b1, 32'h0, 1); push(16'h8000, 16'h0000);
      flush();

      // Lock lands in a right slot: no strobe until a full left+right pair
      do_reset();
      send_slot(1'b0, 32'h0, 4);
      send_slot(1'b1, 32'hFFFF, 16);
      check("locked_into_right", 32'(locked), 32'h1);
      send_slot(1'b0, 32'h0F0F, 16);
      send_slot(1'b1, 32'hF0F0, 16); push(16'h0F0F, 16'hF0F0);
      flush();

      // 100 frames: one single-cycle strobe per frame
      do_reset();
      pulses0 = pulses;
      send_slot(1'b1, 32'h0, 7);
      for (int i = 0; i < 100; i++) begin
         send_slot(1'b0, 32'({8'hA0, 8'(i)}), 16);
         send_slot(1'b1, 32'({8'h5F, ~8'(i)}), 16);
         push({8'hA0, 8'(i)}, {8'h5F, ~8'(i)});
      end
      flush();
      check("pulse_count_100", 32'(pulses - pulses0), 32'd100);

      // Reset during a right slot: that pair is dropped, then resync
      do_reset();
      send_slot(1'b1, 32'h0, 5);
      send_slot(1'b0, 32'hA55A, 16);
      send_slot(1'b1, 32'h1234, 16); push(16'hA55A, 16'h1234);
      send_slot(1'b0, 32'h5A5A, 16);
      for (int i = 15; i >= 9; i--) begin
         send_bit(1'b1, pending);
         pending = 16'hBEEF >> i;
      end
      rst = 1'b0;
      #30;
      check("midrst_locked", 32'(locked), 32'h0);
      check("midrst_valid", 32'(sample_valid), 32'h0);
      check("midrst_left", 32'(left_chan), 32'h0);
      sclk = 1'b0;
      #50;
      rst = 1'b1;
      #20;
      send_slot(1'b1, 32'h0, 9);
      check("midrst_relock_wait", 32'(locked), 32'h0);
      send_slot(1'b0, 32'h1357, 16);
      send_slot(1'b1, 32'h2468, 16); push(16'h1357, 16'h2468);
      flush();

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
